// File: rtl/bsg_arb_tag_fifo_pkg.sv
// Shared width helpers for the arbiter tag FIFO: tag width derivation and
// {tag, data} entry layout (tag in the upper bits, payload in the lower bits).
package bsg_arb_tag_fifo_pkg;

  // Tag width for a given requester count, never narrower than one bit.
  function automatic int lg_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int entry_width(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

  // Index of the lowest tag bit inside a packed entry.
  function automatic int tag_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/bsg_arb_tag_fifo_if.sv
// Arbiter-side and consumer-side signals of bsg_arb_tag_fifo.
// Handshake: arb side transfers when arb_v_i & arb_yumi_o; consumer side
// transfers when v_o & yumi_i, and yumi_i must only be raised while v_o is high.
interface bsg_arb_tag_fifo_if
  import bsg_arb_tag_fifo_pkg::*;
#(
  parameter int inputs_p = 32,
  parameter int width_p  = 32,
  parameter int els_p    = 4
);
  localparam int lg_inputs_lp = lg_min1(inputs_p);
  localparam int count_w_lp   = $clog2(els_p + 1);

  logic                    arb_v_i;
  logic [lg_inputs_lp-1:0] arb_tag_i;
  logic [width_p-1:0]      arb_data_i;
  logic                    arb_yumi_o;
  logic                    v_o;
  logic [lg_inputs_lp-1:0] tag_o;
  logic [width_p-1:0]      data_o;
  logic                    yumi_i;
  logic [count_w_lp-1:0]   count_o;
  logic                    full_o;

  modport slave (
    input  arb_v_i, arb_tag_i, arb_data_i, yumi_i,
    output arb_yumi_o, v_o, tag_o, data_o, count_o, full_o
  );

  modport master (
    output arb_v_i, arb_tag_i, arb_data_i, yumi_i,
    input  arb_yumi_o, v_o, tag_o, data_o, count_o, full_o
  );

endinterface

// File: rtl/bsg_arb_tag_fifo_ptr.sv
// Wrapping pointer register: advances by one on inc_i and wraps from
// els_p-1 back to 0, so non-power-of-two depths work without masking.
module bsg_arb_tag_fifo_ptr #(
  parameter  int els_p    = 4,
  localparam int ptr_w_lp = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                inc_i,
  output logic [ptr_w_lp-1:0] ptr_o
);

  logic [ptr_w_lp-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : ptr_q + ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_arb_tag_fifo.sv
// Grant-capture FIFO behind a round-robin arbiter: stores {tag, data} in order
// and serves a valid/yumi consumer. Define BSG_ARB_TAG_FIFO_BYPASS_EN for 0-cycle bypass when empty.
module bsg_arb_tag_fifo
  import bsg_arb_tag_fifo_pkg::*;
#(
  parameter int inputs_p = 32,
  parameter int width_p  = 32,
  parameter int els_p    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_arb_tag_fifo_if.slave     io
);

  localparam int lg_inputs_lp = lg_min1(inputs_p);
  localparam int entry_w_lp   = entry_width(lg_inputs_lp, width_p);
  localparam int tag_lsb_lp   = tag_lsb(width_p);
  localparam int ptr_w_lp     = $clog2(els_p);
  localparam int count_w_lp   = $clog2(els_p + 1);

  logic [count_w_lp-1:0] count_q, count_d;
  logic [ptr_w_lp-1:0]   rptr, wptr;
  logic [entry_w_lp-1:0] mem_q [els_p];
  logic [entry_w_lp-1:0] head_entry;
  logic                  full, stored_v, out_v, enq, wr_en, deq;

  assign full     = (count_q == count_w_lp'(els_p));
  assign stored_v = (count_q != '0);
  // Acceptance never looks at yumi_i: no pass-through when full.
  assign enq      = io.arb_v_i & ~full;
  assign deq      = stored_v & io.yumi_i;

`ifdef BSG_ARB_TAG_FIFO_BYPASS_EN
  logic byp;
  // Empty queue forwards the arbiter winner straight to the consumer.
  assign byp        = ~stored_v & io.arb_v_i & reset_n_i;
  assign wr_en      = enq & ~(byp & io.yumi_i);
  assign out_v      = stored_v | byp;
  assign head_entry = byp ? {io.arb_tag_i, io.arb_data_i} : mem_q[rptr];
`else
  assign wr_en      = enq;
  assign out_v      = stored_v;
  assign head_entry = mem_q[rptr];
`endif

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, deq})
      2'b10:   count_d = count_q + count_w_lp'(1);
      2'b01:   count_d = count_q - count_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  // Storage is deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr] <= {io.arb_tag_i, io.arb_data_i};
  end

  bsg_arb_tag_fifo_ptr #(.els_p(els_p)) rptr_inst (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (deq),
    .ptr_o     (rptr)
  );

  bsg_arb_tag_fifo_ptr #(.els_p(els_p)) wptr_inst (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (wr_en),
    .ptr_o     (wptr)
  );

  assign io.arb_yumi_o = enq;
  assign io.v_o        = out_v;
  assign io.tag_o      = out_v ? head_entry[tag_lsb_lp +: lg_inputs_lp] : '0;
  assign io.data_o     = out_v ? head_entry[width_p-1:0] : '0;
  assign io.count_o    = count_q;
  assign io.full_o     = full;

  yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io.yumi_i && !out_v));

endmodule

// File: tb/tb_bsg_arb_tag_fifo.sv
// Randomized scoreboard bench for bsg_arb_tag_fifo against a queue-based model.
module tb_bsg_arb_tag_fifo;
  localparam int inputs_p = 32;
  localparam int width_p  = 32;
  localparam int els_p    = 4;
  localparam int lg_lp    = 5;
`ifdef BSG_ARB_TAG_FIFO_BYPASS_EN
  localparam bit byp_lp = 1'b1;
`else
  localparam bit byp_lp = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bsg_arb_tag_fifo_if #(.inputs_p(inputs_p), .width_p(width_p), .els_p(els_p)) bus ();

  bsg_arb_tag_fifo #(.inputs_p(inputs_p), .width_p(width_p), .els_p(els_p)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (bus)
  );

  logic [lg_lp+width_p-1:0] exp_q[$];
  int total   = 0;
  int bad     = 0;
  int mdl_cnt = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; model: bounded queue of els_p entries.
  task automatic drive(input bit v, input logic [lg_lp-1:0] tag,
                       input logic [width_p-1:0] data, input bit yumi);
    bit acc;
    @(negedge clk);
    bus.arb_v_i    = v;
    bus.arb_tag_i  = tag;
    bus.arb_data_i = data;
    bus.yumi_i     = yumi;
    #1;
    acc = v && (mdl_cnt < els_p);
    chk("arb_yumi", 64'(bus.arb_yumi_o), 64'(acc));
    chk("count", 64'(bus.count_o), 64'(mdl_cnt));
    chk("full", 64'(bus.full_o), 64'(mdl_cnt == els_p));
    chk("v_o", 64'(bus.v_o), 64'((mdl_cnt != 0) || (byp_lp && v)));
    if (acc) exp_q.push_back({tag, data});
    mdl_cnt = mdl_cnt + int'(acc) - int'(yumi);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * els_p && mdl_cnt > 0; k++) drive(1'b0, '0, '0, 1'b1);
  endtask

  // monitor: compares the presented head against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (bus.v_o) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL head_no_expected act=%0h req=none", {bus.tag_o, bus.data_o});
          end else begin
            chk("head", 64'({bus.tag_o, bus.data_o}), 64'(exp_q[0]));
            if (bus.yumi_i) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_head_zero", 64'({bus.tag_o, bus.data_o}), 64'(0));
        end
      end
    end
  end

  initial begin
    bit v, y;
    bus.arb_v_i    = 1'b1;
    bus.arb_tag_i  = 5'd9;
    bus.arb_data_i = 32'hdead_beef;
    bus.yumi_i     = 1'b0;
    #1 rst_n = 1'b0;

    // reset held with a pending winner
    repeat (2) @(posedge clk);
    #2;
    chk("rst_arb_yumi", 64'(bus.arb_yumi_o), 64'(1));
    chk("rst_v_o", 64'(bus.v_o), 64'(0));
    chk("rst_count", 64'(bus.count_o), 64'(0));
    chk("rst_full", 64'(bus.full_o), 64'(0));
    chk("rst_tag", 64'(bus.tag_o), 64'(0));
    chk("rst_data", 64'(bus.data_o), 64'(0));
    @(negedge clk);
    bus.arb_v_i = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_count", 64'(bus.count_o), 64'(0));
    chk("release_v_o", 64'(bus.v_o), 64'(0));
    mon_en = 1'b1;

    // fill to full, then a rejected fifth winner
    drive(1'b1, 5'd3, $urandom, 1'b0);
    drive(1'b1, 5'd7, $urandom, 1'b0);
    drive(1'b1, 5'd31, $urandom, 1'b0);
    drive(1'b1, 5'd0, $urandom, 1'b0);
    drive(1'b1, 5'd12, $urandom, 1'b0);
    // drain in order
    repeat (4) drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0);

    // steady state at count 2 with wrapping pointers
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    repeat (10) drive(1'b1, 5'($urandom), $urandom, 1'b1);

    // full with same-cycle dequeue: no pass-through
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    drive(1'b1, 5'd21, $urandom, 1'b1);
    drive(1'b1, 5'd22, $urandom, 1'b0);
    drain();

    if (byp_lp) begin
      drive(1'b1, 5'd5, $urandom, 1'b1);
      drive(1'b1, 5'd5, $urandom, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      drain();
    end

    // asynchronous reset with entries stored
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    drive(1'b1, 5'($urandom), $urandom, 1'b0);
    #1;
    rst_n       = 1'b0;
    bus.arb_v_i = 1'b0;
    bus.yumi_i  = 1'b0;
    #2;
    chk("async_rst_count", 64'(bus.count_o), 64'(0));
    chk("async_rst_v_o", 64'(bus.v_o), 64'(0));
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic with varying pressure
    for (int i = 0; i < 3000; i++) begin
      int pv, py;
      pv = (i < 1000) ? 3 : ((i < 2000) ? 1 : 2);
      py = (i < 1000) ? 1 : ((i < 2000) ? 3 : 2);
      v = ($urandom_range(0, 3) < pv);
      y = ((mdl_cnt > 0) || (byp_lp && v)) && ($urandom_range(0, 3) < py);
      drive(v, 5'($urandom_range(0, inputs_p - 1)), $urandom, y);
    end
    drain();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #4;
    chk("scoreboard_left", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_arb_tag_fifo.md
# bsg_arb_tag_fifo

Grant-capture queue that sits directly downstream of `bsg_round_robin_arb`. Each cycle the arbiter presents a winner, this block accepts the winner's tag and the payload the upstream mux selected, and answers with the arbiter's `yumi`. It buffers `{tag, data}` pairs in order and presents them to a single consumer over a valid/yumi interface. This decouples consumer back-pressure from arbitration, so the arbiter's round-robin pointer only advances when an entry is actually stored.

## Interface
Parameters:
- `inputs_p`, 32: number of arbiter requesters. Tag width `lg_inputs_lp = $clog2(inputs_p)`, minimum 1.
- `width_p`, 32: payload width in bits.
- `els_p`, 4: FIFO depth. Must be ≥ 2; any integer is allowed, not only powers of two.

Ports:
- `clk_i`, input, 1: the single clock; all state updates on its rising edge.
- `reset_n_i`, input, 1: reset, asynchronous and active-low.
- `arb_v_i`, input, 1: arbiter has a winner (arbiter `v_o`).
- `arb_tag_i`, input, `lg_inputs_lp`: winner index (arbiter `tag_o`).
- `arb_data_i`, input, `width_p`: payload of the winning requester.
- `arb_yumi_o`, output, 1: entry accepted this cycle (drives arbiter `yumi_i`).
- `v_o`, input/output direction: output, 1: head entry valid.
- `tag_o`, output, `lg_inputs_lp`: head tag.
- `data_o`, output, `width_p`: head payload.
- `yumi_i`, input, 1: consumer takes the head entry this cycle.
- `count_o`, output, `$clog2(els_p+1)`: number of stored entries.
- `full_o`, output, 1: `count_o == els_p`.

## Operation
- Storage is a circular buffer of `els_p` entries, with a read pointer `rptr` and a write pointer `wptr`, each `$clog2(els_p)` bits, plus an occupancy counter.
- Enqueue: `arb_yumi_o = arb_v_i & ~full_o`. This is purely combinational and does not depend on `yumi_i`.
- On an enqueue, `mem[wptr] <= {arb_tag_i, arb_data_i}`.
- Pointer wrap: a pointer at `els_p-1` advances to 0. No power-of-two masking is used.
- Dequeue: `v_o = (count != 0)`. When `v_o & yumi_i`, `rptr` advances.
- `yumi_i` while `v_o = 0` is a protocol error. It is ignored and flagged by a simulation-only assertion.
- Count update:
  - enqueue only: count +1.
  - dequeue only: count −1.
  - both in the same cycle: count unchanged, both pointers advance.
- Full: `arb_yumi_o = 0` even if `yumi_i = 1` in the same cycle. There is no same-cycle pass-through at full.
- Empty: `v_o = 0`, and `tag_o` and `data_o` are driven to 0.
- Ordering is strict FIFO. The arbiter's fairness order is preserved exactly.

## Timing
- Reset, asynchronous assert:
  - `rptr = wptr = count = 0`.
  - `v_o = 0`, `arb_yumi_o = arb_v_i & 1`, `full_o = 0`, `count_o = 0`, `tag_o = data_o = 0`.
  - Memory contents are not reset.
- Reset asserted mid-operation drops all stored entries immediately, without waiting for a clock edge.
- Deassertion of `reset_n_i` must be synchronized externally to `clk_i`.
- Without bypass, latency is 1 cycle: an entry enqueued at edge N appears at `v_o` after edge N.
- `arb_yumi_o` depends combinationally on `arb_v_i`. The arbiter's `v_o` → `yumi_i` path is therefore one combinational loop-free hop, because the arbiter's `v_o` does not depend on its `yumi_i`.
- `v_o`, `count_o` and `full_o` are registered-state functions. With bypass disabled they have no combinational input dependence.

## Configuration
- `BSG_ARB_TAG_FIFO_BYPASS_EN` undefined (default): behaviour exactly as above, minimum latency 1 cycle.
- `BSG_ARB_TAG_FIFO_BYPASS_EN` defined, when count = 0 and `arb_v_i = 1`:
  - `v_o = 1`, with `tag_o/data_o = arb_tag_i/arb_data_i` combinationally.
  - If `yumi_i = 1` in the same cycle, the entry is consumed and not written; count stays 0 and pointers do not move.
  - Otherwise the entry is written normally.
  - `arb_yumi_o` is unchanged.
  - Latency is 0 cycles. `v_o`, `tag_o` and `data_o` gain combinational paths from the arbiter inputs.

## Structure
- Shared package `bsg_arb_tag_fifo_pkg` holds the parameterized `{tag, data}` entry packing helpers.
- Width constants (`lg_inputs_lp`, count width) are derived locally from parameters.
- One sub-module, `bsg_arb_tag_fifo_ptr`: a wrapping pointer register with increment enable, parameterized by `els_p`. It is instantiated once for `rptr` and once for `wptr`.

## Test plan
- **Reset then idle:** hold `reset_n_i = 0`, drive `arb_v_i = 1` → `arb_yumi_o = 1`, `v_o = 0`, `count_o = 0`, `tag_o = data_o = 0`. After release, no entry appears unless a clock edge occurs with `reset_n_i = 1`.
- **Fill to full:** `els_p = 4`, tags 3,7,31,0 on consecutive cycles with `yumi_i = 0` → `count_o` steps 1,2,3,4. `full_o = 1` after the 4th edge, and a 5th `arb_v_i` sees `arb_yumi_o = 0`.
- **Drain order:** from the full state, `yumi_i = 1` for 4 cycles → `tag_o` sequence 3,7,31,0 with matching data, then `v_o = 0`.
- **Simultaneous enqueue/dequeue:** count = 2, `arb_v_i = yumi_i = 1` for 10 cycles → count stays 2. Pointers wrap past 3→0 at least twice, and the output order equals the input order.
- **Full + dequeue same cycle:** count = 4, `arb_v_i = yumi_i = 1` → `arb_yumi_o = 0`, `count_o = 3` next cycle. Then accept `arb_yumi_o = 1`.
- **Bypass (macro defined):** empty, `arb_v_i = 1`, tag = 5, `yumi_i = 1` → same-cycle `v_o = 1`, `tag_o = 5`, `count_o` stays 0. Repeat with `yumi_i = 0` → `count_o = 1`.
